// File: rtl/layer_ctrl.sv
// Sequencing controller for a fully-connected layer engine: loads an N-vector,
// then sweeps M weight rows through a single MAC and hands out each dot product.
module layer_ctrl #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int PIPE = 0,
  parameter int AWX  = $clog2(N),
  parameter int AWW  = $clog2(M*N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid_x,
  output logic           s_ready_x,
  output logic           m_valid_y,
  input  logic           m_ready_y,
  output logic           x_wr_en,
  output logic [AWX-1:0] x_addr,
  output logic [AWW-1:0] w_addr,
  output logic           acc_en,
  output logic           acc_clr
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (PIPE > 0) ? $clog2(PIPE + 1) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, WAIT, OUT} state_t;

  state_t         state, state_n;
  logic [AWX-1:0] col, col_n;
  logic [RW-1:0]  row, row_n;
  logic [CW-1:0]  wcnt, wcnt_n;
  logic [AWW-1:0] w_addr_n;
  logic           acc_en_n, acc_clr_n;
  logic           col_last, row_last;

  assign col_last = (col == AWX'(N - 1));
  assign row_last = (row == RW'(M - 1));
  assign x_addr   = col;
  assign x_wr_en  = s_valid_x & s_ready_x;

  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    wcnt_n    = wcnt;
    w_addr_n  = w_addr;
    acc_en_n  = 1'b0;
    acc_clr_n = 1'b0;
    unique case (state)
      LOAD: begin
        if (x_wr_en) begin
          if (col_last) begin
            col_n    = '0;
            row_n    = '0;
            w_addr_n = '0;
            state_n  = COMPUTE;
          end else begin
            col_n = col + 1'b1;
          end
        end
      end
      COMPUTE: begin
        acc_en_n  = 1'b1;
        acc_clr_n = (col == '0);
        if (col_last) begin
          col_n   = '0;
          wcnt_n  = '0;
          state_n = WAIT;
          // Wrap after the final row so w_addr never leaves 0..M*N-1
          w_addr_n = row_last ? '0 : w_addr + 1'b1;
        end else begin
          col_n    = col + 1'b1;
          w_addr_n = w_addr + 1'b1;
        end
      end
      WAIT: begin
        if (wcnt == CW'(PIPE)) state_n = OUT;
        else                   wcnt_n  = wcnt + 1'b1;
      end
      OUT: begin
        if (m_ready_y) begin
          if (row_last) begin
            row_n    = '0;
            w_addr_n = '0;
            state_n  = LOAD;
          end else begin
            row_n   = row + 1'b1;
            state_n = COMPUTE;
          end
        end
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      col       <= '0;
      row       <= '0;
      wcnt      <= '0;
      w_addr    <= '0;
      acc_en    <= 1'b0;
      acc_clr   <= 1'b0;
      s_ready_x <= 1'b1;
      m_valid_y <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      wcnt      <= wcnt_n;
      w_addr    <= w_addr_n;
      acc_en    <= acc_en_n;
      acc_clr   <= acc_clr_n;
      s_ready_x <= (state_n == LOAD);
      m_valid_y <= (state_n == OUT);
    end
  end

endmodule

// File: tb/tb_layer_ctrl.sv
// Scoreboard bench for layer_ctrl (M=3, N=4, PIPE=2): stimulus queues expected
// writes, MAC issues and results; a negedge monitor pops and compares them.
module tb_layer_ctrl;
  localparam int M    = 3;
  localparam int N    = 4;
  localparam int PIPE = 2;
  localparam int AWX  = 2;
  localparam int AWW  = 4;
  localparam int LAT  = 8;  // N + 2 + PIPE cycles from trigger to m_valid_y

  logic clk = 1'b0;
  logic reset, s_valid_x, s_ready_x, m_valid_y, m_ready_y, x_wr_en, acc_en, acc_clr;
  logic [AWX-1:0] x_addr;
  logic [AWW-1:0] w_addr;

  always #5 clk = ~clk;

  layer_ctrl #(.M(M), .N(N), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .x_wr_en(x_wr_en), .x_addr(x_addr), .w_addr(w_addr),
    .acc_en(acc_en), .acc_clr(acc_clr)
  );

  int nassert = 0;
  int nfail   = 0;
  int q_wr[$];
  int q_iss[$];
  int q_res[$];
  int cyc = 0, last_trig = 0, res_cnt = 0, last_iss_w = -1;
  logic prev_mv = 1'b0, prev_hs = 1'b0;
  int prev_w = 0, prev_x = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: samples away from the active edge
  always @(negedge clk) begin
    int e;
    cyc++;
    if (!reset) begin
      chk("w_addr_range", 32'(w_addr <= AWW'(M*N-1)), 1);
      if (!s_ready_x) chk("no_write_busy", 32'(x_wr_en), 0);
      if (!acc_en) chk("acc_clr_alone", 32'(acc_clr), 0);
      if (prev_mv && !prev_hs) begin
        chk("mvalid_hold", 32'(m_valid_y), 1);
        chk("w_frozen", 32'(w_addr), prev_w);
        chk("acc_idle_stall", 32'(acc_en), 0);
      end
      if (x_wr_en) begin
        chk("write_expected", 32'(q_wr.size() > 0), 1);
        if (q_wr.size() > 0) chk("wr_addr", 32'(x_addr), q_wr.pop_front());
        last_trig = cyc;
      end
      if (acc_en) begin
        chk("issue_expected", 32'(q_iss.size() > 0), 1);
        if (q_iss.size() > 0) begin
          e = q_iss.pop_front();
          chk("issue_w", prev_w, e);
          chk("issue_x", prev_x, e % N);
          chk("acc_clr", 32'(acc_clr), 32'(e % N == 0));
          last_iss_w = prev_w;
        end
      end
      if (m_valid_y && !prev_mv) begin
        chk("result_expected", 32'(q_res.size() > 0), 1);
        if (q_res.size() > 0) begin
          e = q_res.pop_front();
          chk("latency", cyc - last_trig, LAT);
          chk("row_last_w", last_iss_w, e);
        end
      end
      if (m_valid_y && m_ready_y) begin
        res_cnt++;
        last_trig = cyc;
      end
    end
    prev_mv = m_valid_y;
    prev_hs = m_valid_y && m_ready_y;
    prev_w  = int'(w_addr);
    prev_x  = int'(x_addr);
  end

  task automatic push_vectors(input int k);
    for (int v = 0; v < k; v++) begin
      for (int c = 0; c < N; c++) q_wr.push_back(c);
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) q_iss.push_back(r*N + c);
        q_res.push_back(r*N + N - 1);
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_s_ready"}, 32'(s_ready_x), 1);
    chk({nm, "_m_valid"}, 32'(m_valid_y), 0);
    chk({nm, "_x_wr_en"}, 32'(x_wr_en), 0);
    chk({nm, "_x_addr"},  32'(x_addr), 0);
    chk({nm, "_w_addr"},  32'(w_addr), 0);
    chk({nm, "_acc_en"},  32'(acc_en), 0);
    chk({nm, "_acc_clr"}, 32'(acc_clr), 0);
  endtask

  // vmode: 0 valid until loaded, 1 random, 2 held high outside LOAD
  // rmode: 0 ready always, 1 random, 2 ten-cycle stall on first result
  task automatic run_phase(input string nm, input int k, input int vmode, input int rmode);
    int loaded = 0;
    int target = res_cnt + k*M;
    int stall  = (rmode == 2) ? 10 : 0;
    int guard  = 0;
    push_vectors(k);
    while (res_cnt < target && guard < 200*k + 200) begin
      @(posedge clk); #1;
      guard++;
      case (vmode)
        0: s_valid_x = (loaded < k*N);
        1: s_valid_x = (loaded < k*N) ? 1'($urandom_range(0, 1)) : 1'b0;
        default: s_valid_x = (loaded < k*N) ? 1'b1 : !s_ready_x;
      endcase
      if (s_valid_x && s_ready_x) loaded++;
      case (rmode)
        0: m_ready_y = 1'b1;
        1: m_ready_y = 1'($urandom_range(0, 1));
        default: begin
          if (m_valid_y && stall > 0) begin
            m_ready_y = 1'b0;
            stall--;
          end else begin
            m_ready_y = 1'b1;
          end
        end
      endcase
    end
    s_valid_x = 1'b0;
    chk({nm, "_results"}, res_cnt, target);
    chk({nm, "_loaded"}, loaded, k*N);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_wr_left"}, q_wr.size(), 0);
    chk({nm, "_iss_left"}, q_iss.size(), 0);
    chk({nm, "_res_left"}, q_res.size(), 0);
    chk({nm, "_idle_ready"}, 32'(s_ready_x), 1);
    chk({nm, "_idle_x_addr"}, 32'(x_addr), 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    s_valid_x = 1'b0;
    m_ready_y = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");

    run_phase("basic_hold", 1, 2, 0);
    run_phase("stall", 1, 0, 2);
    run_phase("random", 20, 1, 1);

    // Abandon a vector mid-COMPUTE at row 1, col 2
    m_ready_y = 1'b1;
    push_vectors(1);
    @(posedge clk); #1;
    s_valid_x = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_valid_x = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(w_addr == AWW'(6) && x_addr == AWX'(2)) && guard < 100);
    chk("midreset_reach", 32'(guard < 100), 1);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q_wr.delete();
    q_iss.delete();
    q_res.delete();
    check_reset_vals("midreset");
    repeat (6) @(posedge clk);
    #1;
    chk("midreset_quiet_valid", 32'(m_valid_y), 0);

    run_phase("after_reset", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/layer_ctrl.md
# layer_ctrl

Sequencing controller for one fully-connected layer engine (M×N matrix times N-vector, one MAC per cycle) in the multi-layer network pipeline. It accepts an N-element input vector over a valid/ready stream and drives write/read addresses for the input-vector memory and the weight ROM. It also drives the accumulator enable and clear strobes, and presents each of the M dot-product results on the downstream valid/ready stream. Data words never pass through this block; it controls only the datapath's memories, MAC and output register.

## Interface
- M, 8, number of outputs (weight rows) per input vector; ≥ 1
- N, 8, vector length (weight columns); ≥ 2
- PIPE, 0, extra pipeline stages inside the MAC beyond the accumulator register
- AWX, $clog2(N), input-memory address width (derived)
- AWW, $clog2(M*N), weight-ROM address width (derived)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- s_valid_x  input  1  upstream word valid
- s_ready_x  output  1  controller accepting input words
- m_valid_y  output  1  result for current row valid at datapath output
- m_ready_y  input  1  downstream accepts result
- x_wr_en  output  1  write strobe for input-vector memory
- x_addr  output  AWX  input-memory address (write address in LOAD, read address in COMPUTE)
- w_addr  output  AWW  weight-ROM read address
- acc_en  output  1  accumulator update enable
- acc_clr  output  1  with acc_en: accumulator loads product instead of adding it

## Operation
- States: LOAD, COMPUTE, WAIT, OUT. Counters: col (0..N-1), row (0..M-1), wcnt (0..PIPE).
- LOAD:
  - s_ready_x=1; x_wr_en = s_valid_x & s_ready_x (combinational); x_addr = col.
  - col increments on each handshake.
  - On the handshake with col=N-1: col←0, row←0, w_addr←0, go to COMPUTE.
  - No handshake: hold state.
- COMPUTE:
  - s_ready_x=0; x_wr_en=0; x_addr=col; w_addr = row*N+col, held as a registered linear counter incremented each cycle.
  - Each cycle is one issue; col increments.
  - At col=N-1: col←0, wcnt←0, go to WAIT.
- Strobes (one-cycle memory latency, registered):
  - acc_en is high in the cycle after every issue.
  - acc_clr is high in the cycle after the col=0 issue only.
- WAIT: lasts exactly 1+PIPE cycles (wcnt counts), then go to OUT.
- OUT:
  - m_valid_y=1, held stable until m_ready_y.
  - On the handshake: if row<M-1, row←row+1 and go to COMPUTE next cycle (w_addr continues from row*N). Otherwise row←0, w_addr←0 and go to LOAD.
- No overlap: the next vector is not accepted until the last row's result handshakes.
- No stall inside COMPUTE/WAIT: downstream backpressure acts only in OUT.

## Timing
- Reset values: state=LOAD, col=row=wcnt=0, s_ready_x=1, m_valid_y=0, x_wr_en=0, x_addr=0, w_addr=0, acc_en=0, acc_clr=0.
- Reset mid-operation (any state) abandons the vector: next cycle is LOAD with all reset values; no m_valid_y, acc_en or acc_clr pulse afterward.
- Last input handshake in cycle a ⇒ COMPUTE issues in cycles a+1..a+N.
- acc_en is high in cycles a+2..a+N+1; acc_clr is high in a+2 only.
- WAIT occupies cycles a+N+1..a+N+1+PIPE; m_valid_y rises in cycle a+N+2+PIPE.
- Per-row latency from OUT handshake to next m_valid_y: N+2+PIPE cycles.
- Per-vector cycles with no stalls: N + M*(N+2+PIPE).
- m_valid_y and all address/strobe outputs are registered. x_wr_en is the only combinational output.
- s_valid_x in non-LOAD states is ignored; no write occurs.

## Test plan
- Basic (M=3, N=4, PIPE=0), s_valid_x and m_ready_y held 1:
  - x_wr_en pulses with x_addr 0,1,2,3.
  - w_addr sequence 0..3, 4..7, 8..11.
  - acc_clr pulses 3 times; acc_en has 12 pulses.
  - m_valid_y rises 6 cycles after the last input handshake; 3 results; back in LOAD with s_ready_x=1 after the third handshake.
- PIPE=2, same M/N: m_valid_y rises 8 cycles after the last input; per-row gap of 8 cycles between OUT handshakes.
- Randomized s_valid_x/m_ready_y at 50% over 20 vectors:
  - exactly N writes and M outputs per vector;
  - m_valid_y never drops without a handshake;
  - w_addr never exceeds M*N-1.
- m_ready_y held 0 for 10 cycles in OUT: m_valid_y stays 1; acc_en stays 0; w_addr and state are frozen; releasing m_ready_y resumes with the correct next w_addr.
- Reset asserted in COMPUTE at col=2, row=1: next cycle shows all reset values. A fresh vector then runs clean, with w_addr restarting at 0 and exactly M results.
- s_valid_x held 1 during COMPUTE/WAIT/OUT: x_wr_en stays 0 and input memory is unwritten. The LOAD counter resumes at x_addr 0 for the next vector.
